// File: rtl/uart_char_pkg.sv
// Shared types and constants for the serial character receiver.
//   rx_state_t  : receiver FSM states
//   CHAR_W      : width of the parallel character bus
//   ASCII_LC_*  : lower-case letter range used by the downstream toupper stage
package uart_char_pkg;

    localparam int unsigned CHAR_W = 8;

    localparam logic [CHAR_W-1:0] ASCII_LC_A = 8'h61;
    localparam logic [CHAR_W-1:0] ASCII_LC_Z = 8'h7A;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both stages reset to 1 so a reset never looks like a start bit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   rxd   : raw serial input, asynchronous to clk
//   rxd_s : synchronised serial line, two clk edges behind rxd
module rx_sync
    import uart_char_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic rxd_s
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], rxd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rxd_s = sync_q[1];

endmodule

// File: rtl/uart_char_rx.sv
// 8N1 serial character receiver (LSB first) with a one-entry output register.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   rxd        : serial line, idle high
//   char_out   : received byte (bit 7 -> toupper i7 ... bit 0 -> i0)
//   char_valid : char_out holds an unconsumed byte
//   char_ready : consumer takes char_out this cycle when char_valid is high
//   frame_err  : one-cycle pulse, stop bit sampled low, byte discarded
//   overrun    : one-cycle pulse, byte completed while holding register full, byte dropped
module uart_char_rx
    import uart_char_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned   CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic rxd_s;

    rx_sync u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .rxd_s (rxd_s)
    );

    rx_state_t         state_q,     state_d;
    logic [CntW-1:0]   cnt_q,       cnt_d;
    logic [2:0]        idx_q,       idx_d;
    logic [CHAR_W-1:0] shift_q,     shift_d;
    logic              rxd_prev_q,  rxd_prev_d;
    logic [CHAR_W-1:0] char_q,      char_d;
    logic              valid_q,     valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q,   overrun_d;
    logic              deliver;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CntW'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        rxd_prev_d  = rxd_s;
        char_d      = char_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        if (valid_q && char_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Edge, not level: a line stuck low must not retrigger.
                if (rxd_prev_q && !rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[CHAR_W-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxd_s) begin
                        deliver = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A consumer taking the old byte in the delivery cycle frees the slot.
        if (deliver) begin
            if (!valid_q || char_ready) begin
                char_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= '0;
            rxd_prev_q  <= 1'b1;
            char_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rxd_prev_q  <= rxd_prev_d;
            char_q      <= char_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/uart_char_rx.md
# uart_char_rx

Serial character receiver that feeds the combinational toupper stage. Deserialises an asynchronous 8N1 line (LSB first) into parallel bytes and holds each byte in a one-entry output register with a valid/ready handshake. The byte bus drives the toupper input bits i7..i0 directly. Detects framing errors and overruns.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; even, ≥ 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  serial line; idle high; asynchronous to clk.
- char_out  output  8  received byte; bit 7 maps to i7, bit 0 to i0.
- char_valid  output  1  char_out holds an unconsumed byte.
- char_ready  input  1  consumer accepts char_out this cycle when char_valid=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
- overrun  output  1  one-cycle pulse: byte completed while holding register full; new byte dropped.

## Operation
- rxd passes through a 2-flop synchroniser (both flops reset to 1) to give rxd_s. Falling-edge detect compares rxd_s with its previous value (also reset to 1).
- Let N=CLKS_PER_BIT and H=N/2. The bit counter runs 0..N-1. The data shift register is 8 bits, shifted right and filled from bit 7.
- States:
  - IDLE: a falling edge of rxd_s moves to START with cnt=0. A line held steadily low does not retrigger.
  - START: at cnt=H-1, sample rxd_s. 0 → DATA with cnt=0 and bit index=0. 1 → IDLE (false start, no output).
  - DATA: at cnt=N-1, sample rxd_s into the shift register, clear cnt and increment the index. After the 8th sample → STOP.
  - STOP: at cnt=N-1, sample rxd_s. 1 → deliver the byte, then IDLE. 0 → pulse frame_err, then IDLE.
- Delivery:
  - If char_valid=0, or char_ready=1 in the same cycle: load char_out and set char_valid=1.
  - Otherwise: keep the old byte, pulse overrun, drop the new byte.
- Handshake:
  - char_valid clears on char_valid & char_ready unless a new byte delivers in that same cycle.
  - char_out is stable while char_valid=1 and not yet accepted.
- No sticky status; frame_err and overrun never assert together.

## Timing
- Reset values: char_out=8'h00, char_valid=0, frame_err=0, overrun=0, state=IDLE, cnt=0, index=0.
- Reset asserted mid-byte aborts immediately. After release the block waits for a new falling edge.
- Input latency: a rxd edge reaches rxd_s 2 clk edges later.
- Let T0 be the first cycle in START:
  - start sample at T0+H-1
  - data bit k (0..7) at T0+H-1+(k+1)·N
  - stop sample at T0+H-1+9N
  - char_valid, frame_err or overrun visible at T0+H+9N
- Back-to-back frames: the next falling edge can be detected from the first cycle back in IDLE.
- char_ready may be held high permanently. Each byte is then valid for exactly one cycle.

## Structure
- Package uart_char_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP)
  - CHAR_W=8
  - the toupper-related ASCII constants ASCII_LC_A=8'h61 and ASCII_LC_Z=8'h7A, for shared use by benches
- Sub-module rx_sync: 2-flop reset-to-1 synchroniser, output rxd_s. Everything else lives in uart_char_rx.
- Estimated 150–250 lines RTL.

## Test plan
- N=16, ready=1, send 0x61 ('a'): char_out=0x61 with char_valid=1 for one cycle at T0+8+144. Fed through toupper it yields 0x41.
- 3-cycle low glitch on an idle line: START samples 1 at cnt=7; no char_valid, frame_err or overrun.
- Send 0x7A with stop bit forced low: frame_err pulses once at T0+152; char_valid stays 0. The next valid frame 0x62 is received correctly.
- ready=0, send 0x61 then 0x62 back-to-back: char_out stays 0x61 and valid, overrun pulses at the second frame's end. Raising ready clears valid the next cycle.
- ready pulsed 1 in exactly the delivery cycle of a second byte (0x63 pending, 0x64 arriving): char_out becomes 0x64, char_valid stays 1, no overrun.
- Assert rst_n=0 during DATA bit 4 of 0x55: all outputs return to reset values. After release, 0x41 is received correctly with no residual bits.
